// File: rtl/elevator_car_model.sv
`default_nettype none
// ---------------------------------------------------------------------------
// elevator_car_model : car/shaft plant for the elevator controller loop
// Revision 1.0
// ---------------------------------------------------------------------------
module elevator_car_model #(
   parameter int         NUM_FLOORS    = 16,
   parameter int         FLOOR_W       = 4,
   parameter int         TRAVEL_CYCLES = 8,
   parameter int         DOOR_CYCLES   = 4,
   parameter logic [7:0] MAX_WEIGHT    = 8'd200
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [1:0]         direction_i,
   input  logic               complete_i,
   input  logic [7:0]         load_in_i,
   input  logic               door_block_i,
   output logic [FLOOR_W-1:0] current_floor_o,
   output logic               floor_tick_o,
   output logic               moving_o,
   output logic               door_open_o,
   output logic               over_weight_o,
   output logic               limit_fault_o
);

   localparam int TIMER_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int TIMER_W   = $clog2(TIMER_MAX);

   localparam logic [TIMER_W-1:0] C_TRAVEL_RELOAD = TIMER_W'(TRAVEL_CYCLES - 1);
   localparam logic [TIMER_W-1:0] C_DOOR_RELOAD   = TIMER_W'(DOOR_CYCLES - 1);
   localparam logic [FLOOR_W-1:0] C_TOP_FLOOR     = FLOOR_W'(NUM_FLOORS - 1);
   localparam logic [FLOOR_W-1:0] C_BOT_FLOOR     = '0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MOVE = 2'd1,
      ST_DOOR = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [FLOOR_W-1:0]   floor_q, floor_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic                 dir_up_q, dir_up_d;
   logic                 tick_q, tick_d;
   logic                 fault_q, fault_d;
   logic                 ow_q;

   logic                 w_req_up, w_req_dn, w_at_top, w_at_bot;
   logic [FLOOR_W-1:0]   w_next_floor;
   logic                 w_can_step, w_keep_going;

   assign w_req_up = (direction_i == 2'b01);
   assign w_req_dn = (direction_i == 2'b10);
   assign w_at_top = (floor_q == C_TOP_FLOOR);
   assign w_at_bot = (floor_q == C_BOT_FLOOR);

   // Step guarded against the shaft ends so the floor index can never wrap.
   assign w_can_step   = dir_up_q ? !w_at_top : !w_at_bot;
   assign w_next_floor = dir_up_q ? (floor_q + FLOOR_W'(1)) : (floor_q - FLOOR_W'(1));
   assign w_keep_going = (dir_up_q ? (w_req_up && (w_next_floor != C_TOP_FLOOR))
                                   : (w_req_dn && (w_next_floor != C_BOT_FLOOR)))
                         && !ow_q;

   always_comb begin
      state_d  = state_q;
      floor_d  = floor_q;
      timer_d  = timer_q;
      dir_up_d = dir_up_q;
      tick_d   = 1'b0;
      fault_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (complete_i) begin
               state_d = ST_DOOR;
               timer_d = C_DOOR_RELOAD;
            end else if (w_req_up) begin
               if (w_at_top) begin
                  fault_d = 1'b1;
               end else if (!ow_q) begin
                  state_d  = ST_MOVE;
                  dir_up_d = 1'b1;
                  timer_d  = C_TRAVEL_RELOAD;
               end
            end else if (w_req_dn) begin
               if (w_at_bot) begin
                  fault_d = 1'b1;
               end else if (!ow_q) begin
                  state_d  = ST_MOVE;
                  dir_up_d = 1'b0;
                  timer_d  = C_TRAVEL_RELOAD;
               end
            end
         end
         ST_MOVE: begin
            if (timer_q != '0) begin
               timer_d = timer_q - TIMER_W'(1);
            end else if (w_can_step) begin
               floor_d = w_next_floor;
               tick_d  = 1'b1;
               if (w_keep_going) begin
                  timer_d = C_TRAVEL_RELOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DOOR: begin
            if (complete_i || door_block_i) begin
               timer_d = C_DOOR_RELOAD;
            end else if (timer_q == '0) begin
               state_d = ST_IDLE;
            end else begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q  <= ST_IDLE;
         floor_q  <= '0;
         timer_q  <= '0;
         dir_up_q <= 1'b1;
         tick_q   <= 1'b0;
         fault_q  <= 1'b0;
         ow_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         floor_q  <= floor_d;
         timer_q  <= timer_d;
         dir_up_q <= dir_up_d;
         tick_q   <= tick_d;
         fault_q  <= fault_d;
         ow_q     <= (load_in_i > MAX_WEIGHT);
      end
   end

   assign current_floor_o = floor_q;
   assign floor_tick_o    = tick_q;
   assign moving_o        = (state_q == ST_MOVE);
   assign door_open_o     = (state_q == ST_DOOR);
   assign over_weight_o   = ow_q;
   assign limit_fault_o   = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_elevator_car_model.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_elevator_car_model : directed scoreboard bench for elevator_car_model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_elevator_car_model;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic [1:0] direction_i = 2'b00;
    logic       complete_i = 1'b0;
    logic [7:0] load_in_i = 8'd0;
    logic       door_block_i = 1'b0;
    logic [3:0] current_floor_o;
    logic       floor_tick_o, moving_o, door_open_o, over_weight_o, limit_fault_o;

    elevator_car_model dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .direction_i     (direction_i),
        .complete_i      (complete_i),
        .load_in_i       (load_in_i),
        .door_block_i    (door_block_i),
        .current_floor_o (current_floor_o),
        .floor_tick_o    (floor_tick_o),
        .moving_o        (moving_o),
        .door_open_o     (door_open_o),
        .over_weight_o   (over_weight_o),
        .limit_fault_o   (limit_fault_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      nm;
        logic [8:0] v;   // {floor, tick, moving, door, over_weight, fault}
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops every expectation scheduled for the current cycle.
    always @(negedge clk) begin
        logic [8:0] got;
        exp_t       e;
        got = {current_floor_o, floor_tick_o, moving_o, door_open_o, over_weight_o, limit_fault_o};
        while (q.size() != 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            n_chk++;
            if (e.cyc != cyc || got !== e.v) begin
                n_fail++;
                $display("FAIL %s @cycle %0d: got fl=%0d tk=%b mv=%b dr=%b ow=%b lf=%b, want fl=%0d tk=%b mv=%b dr=%b ow=%b lf=%b",
                         e.nm, cyc, got[8:5], got[4], got[3], got[2], got[1], got[0],
                         e.v[8:5], e.v[4], e.v[3], e.v[2], e.v[1], e.v[0]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input int d, input string nm, input logic [3:0] fl,
                              input logic tk, input logic mv, input logic dr,
                              input logic ow, input logic lf);
        exp_t e;
        e.cyc = cyc + d;
        e.nm  = nm;
        e.v   = {fl, tk, mv, dr, ow, lf};
        q.push_back(e);
    endtask

    // One-cycle direction pulse: one floor of travel, then back to idle.
    task automatic move_pulse(input logic up, input logic [3:0] from, input string nm);
        logic [3:0] to;
        to = up ? from + 4'd1 : from - 4'd1;
        expect_out(1,  {nm, "_start"}, from, 0, 1, 0, 0, 0);
        expect_out(8,  {nm, "_last"},  from, 0, 1, 0, 0, 0);
        expect_out(9,  {nm, "_tick"},  to,   1, 0, 0, 0, 0);
        expect_out(10, {nm, "_idle"},  to,   0, 0, 0, 0, 0);
        direction_i = up ? 2'b01 : 2'b10;
        step(1);
        direction_i = 2'b00;
        step(9);
    endtask

    initial begin
        step(2);
        expect_out(0, "reset_state", 0, 0, 0, 0, 0, 0);
        n_chk++;
        if (current_floor_o !== 4'd0 || moving_o !== 1'b0 || door_open_o !== 1'b0 || limit_fault_o !== 1'b0) begin
            n_fail++;
            $display("FAIL direct_reset: fl=%0d mv=%b dr=%b lf=%b", current_floor_o, moving_o, door_open_o, limit_fault_o);
        end
        reset_i = 1'b1;
        step(1);

        // Continuous travel for three floors
        direction_i = 2'b01;
        expect_out(1,  "up3_start", 0, 0, 1, 0, 0, 0);
        expect_out(8,  "up3_pre1",  0, 0, 1, 0, 0, 0);
        expect_out(9,  "up3_tick1", 1, 1, 1, 0, 0, 0);
        expect_out(10, "up3_post1", 1, 0, 1, 0, 0, 0);
        expect_out(17, "up3_tick2", 2, 1, 1, 0, 0, 0);
        expect_out(25, "up3_tick3", 3, 1, 0, 0, 0, 0);
        expect_out(26, "up3_idle",  3, 0, 0, 0, 0, 0);
        step(24);
        direction_i = 2'b00;
        step(2);
        n_chk++;
        if (current_floor_o !== 4'd3 || moving_o !== 1'b0) begin
            n_fail++;
            $display("FAIL direct_up3: fl=%0d mv=%b", current_floor_o, moving_o);
        end

        // Single-floor pulses down: 3->2, 2->1
        move_pulse(1'b0, 4'd3, "dn_3to2");
        move_pulse(1'b0, 4'd2, "dn_2to1");

        // Long run to the top floor, then a request beyond it
        direction_i = 2'b01;
        expect_out(9,   "top_tick2",  2,  1, 1, 0, 0, 0);
        expect_out(105, "top_tick14", 14, 1, 1, 0, 0, 0);
        expect_out(113, "top_arrive", 15, 1, 0, 0, 0, 0);
        expect_out(114, "top_idle",   15, 0, 0, 0, 0, 0);
        step(113);
        direction_i = 2'b00;
        step(1);
        n_chk++;
        if (current_floor_o !== 4'd15 || moving_o !== 1'b0) begin
            n_fail++;
            $display("FAIL direct_top: fl=%0d mv=%b", current_floor_o, moving_o);
        end
        direction_i = 2'b01;
        expect_out(1, "top_fault",     15, 0, 0, 0, 0, 1);
        expect_out(2, "top_fault_end", 15, 0, 0, 0, 0, 0);
        step(1);
        direction_i = 2'b00;
        step(2);

        // Long run down to floor 0, then a request below it
        direction_i = 2'b10;
        expect_out(9,   "bot_tick14", 14, 1, 1, 0, 0, 0);
        expect_out(121, "bot_arrive", 0,  1, 0, 0, 0, 0);
        step(121);
        direction_i = 2'b00;
        step(1);
        n_chk++;
        if (current_floor_o !== 4'd0 || moving_o !== 1'b0) begin
            n_fail++;
            $display("FAIL direct_bot: fl=%0d mv=%b", current_floor_o, moving_o);
        end
        direction_i = 2'b10;
        expect_out(1, "bot_fault",     0, 0, 0, 0, 0, 1);
        expect_out(2, "bot_fault_end", 0, 0, 0, 0, 0, 0);
        step(1);
        direction_i = 2'b00;
        step(2);

        // Over-weight blocks a move; clearing the load lets it start
        load_in_i = 8'd201;
        expect_out(1, "ow_set", 0, 0, 0, 0, 1, 0);
        step(1);
        direction_i = 2'b01;
        expect_out(1, "ow_nomove1", 0, 0, 0, 0, 1, 0);
        expect_out(2, "ow_nomove2", 0, 0, 0, 0, 1, 0);
        step(2);
        load_in_i = 8'd200;
        expect_out(1, "ow_clear", 0, 0, 0, 0, 0, 0);
        expect_out(2, "ow_move",  0, 0, 1, 0, 0, 0);
        step(2);
        direction_i = 2'b00;
        expect_out(8, "ow_arrive", 1, 1, 0, 0, 0, 0);
        step(9);

        // Door cycle with direction asserted while open
        complete_i = 1'b1;
        expect_out(1, "door_open", 1, 0, 0, 1, 0, 0);
        step(1);
        complete_i  = 1'b0;
        direction_i = 2'b01;
        expect_out(3, "door_last", 1, 0, 0, 1, 0, 0);
        step(3);
        direction_i = 2'b00;
        expect_out(1, "door_close",  1, 0, 0, 0, 0, 0);
        expect_out(2, "door_nomove", 1, 0, 0, 0, 0, 0);
        step(2);

        // Door held by an obstruction
        complete_i = 1'b1;
        step(1);
        complete_i = 1'b0;
        step(1);
        door_block_i = 1'b1;
        expect_out(6, "block_held", 1, 0, 0, 1, 0, 0);
        step(6);
        door_block_i = 1'b0;
        expect_out(3, "block_last",  1, 0, 0, 1, 0, 0);
        expect_out(4, "block_close", 1, 0, 0, 0, 0, 0);
        step(5);

        // Reset mid-move (timer at 3) with a heavy load applied
        direction_i = 2'b01;
        load_in_i   = 8'd250;
        expect_out(5, "rst_pre", 1, 0, 1, 0, 1, 0);
        step(5);
        reset_i     = 1'b0;
        direction_i = 2'b00;
        expect_out(1, "rst_clear", 0, 0, 0, 0, 0, 0);
        step(1);
        reset_i = 1'b1;
        expect_out(1, "rst_ow_back", 0, 0, 0, 0, 1, 0);
        step(2);
        load_in_i = 8'd0;

        for (int i = 0; i < 50 && q.size() != 0; i++) step(1);
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL %s: never checked, scheduled cycle %0d, now %0d", e.nm, e.cyc, cyc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks pending", q.size());
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/elevator_car_model.md
Name: elevator_car_model

Overview:
Behavioural-synthesizable model of the elevator car and shaft: the plant end of the elevator controller interface. It consumes the controller's direction and complete outputs and produces the current-floor feedback, door state and weight-sensor flag that the controller samples. It is used on-chip as a self-contained demo loop and as the stimulus partner in controller verification.

Parameters:
NUM_FLOORS, 16, number of floors; floors are numbered 0..NUM_FLOORS-1
FLOOR_W, 4, floor index width; must satisfy 2^FLOOR_W >= NUM_FLOORS
TRAVEL_CYCLES, 8, clock cycles to travel one floor (>=2)
DOOR_CYCLES, 4, clock cycles the door stays open (>=1)
MAX_WEIGHT, 200, load threshold in sensor units, 8-bit

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
direction  input  2  controller command: 00 hold, 01 up, 10 down, 11 illegal (treated as hold)
complete  input  1  controller arrival indication; requests a door cycle
load_in  input  8  raw weight sensor value
door_block  input  1  obstruction sensor; extends door-open time
current_floor  output  FLOOR_W  car floor, fed back as the controller's floor input
floor_tick  output  1  one-cycle pulse on each floor change
moving  output  1  high while in MOVE
door_open  output  1  high while in DOOR
over_weight  output  1  registered (load_in > MAX_WEIGHT)
limit_fault  output  1  one-cycle pulse on a move request beyond the top or bottom floor

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE, current_floor=0, timer=0, committed dir=up. All outputs are 0. Reset mid-move or mid-door aborts immediately and takes no partial floor step.
- over_weight is updated every cycle from load_in with 1-cycle latency, in every state.
- FSM states are IDLE, MOVE, DOOR. Priority in IDLE: complete > move request.
- IDLE:
  - complete=1 -> DOOR, timer=DOOR_CYCLES-1.
  - direction=01:
    - At floor NUM_FLOORS-1: limit_fault pulses next cycle and the FSM stays in IDLE.
    - If over_weight=1: stay in IDLE with no fault.
    - Otherwise: MOVE, committed dir=up, timer=TRAVEL_CYCLES-1.
  - direction=10: handled symmetrically, with the limit at floor 0.
  - direction=00 or 11: stay in IDLE.
- MOVE:
  - moving=1. Timer decrements each cycle.
  - Reaching timer==0:
    - current_floor steps by +/-1 per committed dir at the next edge.
    - floor_tick=1 for that same one cycle, aligned with the new current_floor value.
    - If direction still equals the committed dir, the new floor is not the limit, and over_weight=0: remain in MOVE and reload the timer to TRAVEL_CYCLES-1 (continuous travel, exactly TRAVEL_CYCLES cycles per floor).
    - Otherwise: go to IDLE.
  - A direction change or hold mid-floor does not abort the move. The car always finishes the floor in progress (no fractional floors).
  - complete during MOVE is ignored.
- DOOR:
  - door_open=1. Timer decrements each cycle.
  - complete=1 or door_block=1 reloads the timer to DOOR_CYCLES-1.
  - At timer==0 with neither asserted: go to IDLE.
  - direction is ignored; the car never moves with the door open.
- Floor arithmetic never wraps: current_floor stays in 0..NUM_FLOORS-1 under all input sequences.
- Total open time with no reload is DOOR_CYCLES cycles.
- Simultaneous reset and any input: reset wins.

Test Plan:
- Reset, then apply direction=01 for 3*TRAVEL_CYCLES = 24 cycles and set it to 00 -> floor_tick at cycles 8, 16, 24; current_floor ends at 3; moving drops after the 3rd tick.
- At floor 2, pulse direction=10 for 1 cycle -> moving for 8 cycles; current_floor=1 with one tick; back to IDLE.
- At floor 15 (NUM_FLOORS-1), drive direction=01 -> limit_fault pulses one cycle; current_floor stays 15; moving stays 0. Mirror case: at floor 0 with direction=10 -> same result.
- Set load_in=201, then direction=01 -> over_weight=1 after 1 cycle; no move. Set load_in=200 -> over_weight=0 and the move starts.
- Pulse complete in IDLE -> door_open high for exactly 4 cycles. Hold door_block for 6 cycles mid-open -> door_open is extended to close 4 cycles after door_block falls. direction=01 during DOOR causes no move.
- Mid-MOVE (timer=3), pull reset low for 1 cycle -> all outputs 0 and current_floor=0 on the next cycle.
